// File: rtl/crc8_checker.sv
// Receive-side CRC-8 frame checker: recomputes CRC over payload bytes and compares with the trailing CRC byte.
// Optional error counter enabled by defining CRC8_CHECKER_ERR_CNT_EN.
module crc8_checker #(
  parameter logic [7:0] POLYNOMIAL = 8'h07,
  parameter int         MAX_LEN    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic [7:0] data_in,
  input  logic       data_last,
  output logic       in_ready,
  output logic       result_valid,
  output logic       crc_ok,
  output logic       crc_err,
  output logic       len_err,
  output logic [7:0] crc_calc,
  output logic [7:0] crc_rx,
  output logic [7:0] frame_len
`ifdef CRC8_CHECKER_ERR_CNT_EN
  ,
  input  logic        err_count_clr,
  output logic [15:0] err_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    RESULT
  } state_t;

  // Count is one bit wider than frame_len so MAX_LEN+1 is representable even for MAX_LEN=255.
  localparam logic [8:0] MAX_CNT = 9'(MAX_LEN);

  state_t     state;
  logic [7:0] crc;
  logic [8:0] count;
  logic       accept;
  logic       len_over;
  logic       match;

  function automatic logic [7:0] upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = c ^ b;
    for (int i = 0; i < 8; i++) begin
      x = x[7] ? ((x << 1) ^ POLYNOMIAL) : (x << 1);
    end
    return x;
  endfunction

  assign accept   = data_valid && in_ready;
  assign len_over = (count > MAX_CNT);
  assign match    = (crc == data_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      crc          <= 8'h00;
      count        <= 9'd0;
      in_ready     <= 1'b1;
      result_valid <= 1'b0;
      crc_ok       <= 1'b0;
      crc_err      <= 1'b0;
      len_err      <= 1'b0;
      crc_calc     <= 8'h00;
      crc_rx       <= 8'h00;
      frame_len    <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (data_last) begin
              // A CRC byte with no payload is a zero-length frame.
              crc_rx       <= data_in;
              crc_calc     <= 8'h00;
              frame_len    <= 8'h00;
              len_err      <= 1'b1;
              crc_ok       <= 1'b0;
              crc_err      <= 1'b1;
              result_valid <= 1'b1;
              in_ready     <= 1'b0;
              state        <= RESULT;
            end else begin
              crc   <= upd(8'h00, data_in);
              count <= 9'd1;
              state <= RECV;
            end
          end
        end
        RECV: begin
          if (accept) begin
            if (data_last) begin
              crc_rx       <= data_in;
              crc_calc     <= crc;
              frame_len    <= count[8] ? 8'hFF : count[7:0];
              len_err      <= len_over;
              crc_ok       <= match && !len_over;
              crc_err      <= !(match && !len_over);
              result_valid <= 1'b1;
              in_ready     <= 1'b0;
              state        <= RESULT;
            end else begin
              crc <= upd(crc, data_in);
              if (count <= MAX_CNT) begin
                count <= count + 9'd1;
              end
            end
          end
        end
        RESULT: begin
          result_valid <= 1'b0;
          in_ready     <= 1'b1;
          crc          <= 8'h00;
          count        <= 9'd0;
          state        <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef CRC8_CHECKER_ERR_CNT_EN
  // Saturating failed-frame counter; a clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= 16'h0000;
    end else if (err_count_clr) begin
      err_count <= 16'h0000;
    end else if (result_valid && crc_err && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crc8_checker.sv
// Directed testbench for crc8_checker with hand-computed CRC-8 (poly 0x07) expectations.
// Error-counter checks run only when CRC8_CHECKER_ERR_CNT_EN is defined.
module tb_crc8_checker;

  logic       clk;
  logic       rst;
  logic       data_valid;
  logic [7:0] data_in;
  logic       data_last;
  logic       in_ready;
  logic       result_valid;
  logic       crc_ok;
  logic       crc_err;
  logic       len_err;
  logic [7:0] crc_calc;
  logic [7:0] crc_rx;
  logic [7:0] frame_len;
`ifdef CRC8_CHECKER_ERR_CNT_EN
  logic        err_count_clr;
  logic [15:0] err_count;
`endif

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  crc8_checker #(.POLYNOMIAL(8'h07), .MAX_LEN(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_valid   (data_valid),
    .data_in      (data_in),
    .data_last    (data_last),
    .in_ready     (in_ready),
    .result_valid (result_valid),
    .crc_ok       (crc_ok),
    .crc_err      (crc_err),
    .len_err      (len_err),
    .crc_calc     (crc_calc),
    .crc_rx       (crc_rx),
    .frame_len    (frame_len)
`ifdef CRC8_CHECKER_ERR_CNT_EN
    ,
    .err_count_clr(err_count_clr),
    .err_count    (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (result_valid === 1'b1) pulses++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // {result_valid, in_ready, crc_ok, crc_err, len_err, crc_calc, crc_rx, frame_len}
  function automatic logic [28:0] snap();
    return {result_valid, in_ready, crc_ok, crc_err, len_err, crc_calc, crc_rx, frame_len};
  endfunction

  // Present one byte and hold it until accepted; reports the number of stall cycles.
  task automatic send_byte(input logic [7:0] b, input logic last, output int waits);
    data_valid = 1'b1;
    data_in    = b;
    data_last  = last;
    waits      = 0;
    while (in_ready !== 1'b1 && waits < 10) begin
      @(posedge clk); #1;
      waits++;
    end
    if (waits >= 10) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    data_valid = 1'b0;
    data_last  = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    data_last  = 1'b0;
`ifdef CRC8_CHECKER_ERR_CNT_EN
    err_count_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (snap() !== {5'b01000, 24'h000000}) begin
      failures++;
      $display("[TB] FAIL reset_state: got %h required %h", snap(), {5'b01000, 24'h000000});
    end
`ifdef CRC8_CHECKER_ERR_CNT_EN
    checks++;
    if (err_count !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_err_count: got %h required 0000", err_count);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame;
    int w;
    int p0;
    p0 = pulses;
    send_byte(8'h01, 1'b0, w);
    send_byte(8'h07, 1'b1, w);
    checks++;
    if (snap() !== {5'b10100, 8'h07, 8'h07, 8'h01}) begin
      failures++;
      $display("[TB] FAIL single_frame: got %h required %h", snap(), {5'b10100, 8'h07, 8'h07, 8'h01});
    end
    idle(2);
    checks++;
    if ({result_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL single_after: got rv/ready %b required 01", {result_valid, in_ready});
    end
    checks++;
    if (pulses - p0 !== 1) begin
      failures++;
      $display("[TB] FAIL single_pulses: got %0d required 1", pulses - p0);
    end
  endtask

  task automatic test_check_value;
    int w;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i), 1'b0, w);
      send_byte((pass == 0) ? 8'hF4 : 8'hF5, 1'b1, w);
      if (pass == 0) begin
        checks++;
        if (snap() !== {5'b10100, 8'hF4, 8'hF4, 8'h09}) begin
          failures++;
          $display("[TB] FAIL check_value_ok: got %h required %h", snap(), {5'b10100, 8'hF4, 8'hF4, 8'h09});
        end
      end else begin
        checks++;
        if (snap() !== {5'b10010, 8'hF4, 8'hF5, 8'h09}) begin
          failures++;
          $display("[TB] FAIL check_value_bad: got %h required %h", snap(), {5'b10010, 8'hF4, 8'hF5, 8'h09});
        end
      end
      idle(1);
    end
  endtask

  task automatic test_back_to_back;
    int w;
    int p0;
    p0 = pulses;
    send_byte(8'hFF, 1'b0, w);
    send_byte(8'hF3, 1'b1, w);
    checks++;
    if (snap() !== {5'b10100, 8'hF3, 8'hF3, 8'h01}) begin
      failures++;
      $display("[TB] FAIL b2b_first: got %h required %h", snap(), {5'b10100, 8'hF3, 8'hF3, 8'h01});
    end
    send_byte(8'h00, 1'b0, w);
    checks++;
    if (w !== 1) begin
      failures++;
      $display("[TB] FAIL b2b_stall: got %0d stall cycles required 1", w);
    end
    send_byte(8'h00, 1'b1, w);
    checks++;
    if (snap() !== {5'b10100, 8'h00, 8'h00, 8'h01}) begin
      failures++;
      $display("[TB] FAIL b2b_second: got %h required %h", snap(), {5'b10100, 8'h00, 8'h00, 8'h01});
    end
    send_byte(8'h01, 1'b0, w);
    checks++;
    if (w !== 1) begin
      failures++;
      $display("[TB] FAIL b2b_stall2: got %0d stall cycles required 1", w);
    end
    send_byte(8'h07, 1'b1, w);
    idle(1);
    checks++;
    if (pulses - p0 !== 3) begin
      failures++;
      $display("[TB] FAIL b2b_pulses: got %0d required 3", pulses - p0);
    end
  endtask

  task automatic test_len_err;
    int w;
    send_byte(8'hAA, 1'b1, w);
    checks++;
    if (snap() !== {5'b10011, 8'h00, 8'hAA, 8'h00}) begin
      failures++;
      $display("[TB] FAIL len_zero: got %h required %h", snap(), {5'b10011, 8'h00, 8'hAA, 8'h00});
    end
    idle(1);
    // All-zero payloads keep the CRC at 0x00, so 0x00 is the correct CRC byte.
    for (int i = 0; i < 64; i++) send_byte(8'h00, 1'b0, w);
    send_byte(8'h00, 1'b1, w);
    checks++;
    if (snap() !== {5'b10100, 8'h00, 8'h00, 8'h40}) begin
      failures++;
      $display("[TB] FAIL len_max: got %h required %h", snap(), {5'b10100, 8'h00, 8'h00, 8'h40});
    end
    idle(1);
    for (int i = 0; i < 65; i++) send_byte(8'h00, 1'b0, w);
    send_byte(8'h00, 1'b1, w);
    checks++;
    if (snap() !== {5'b10011, 8'h00, 8'h00, 8'h41}) begin
      failures++;
      $display("[TB] FAIL len_over: got %h required %h", snap(), {5'b10011, 8'h00, 8'h00, 8'h41});
    end
    idle(1);
    // Non-zero overlong payload: CRC keeps updating and count saturates.
    send_byte(8'h01, 1'b0, w);
    for (int i = 0; i < 66; i++) send_byte(8'h00, 1'b0, w);
    send_byte(8'h00, 1'b1, w);
    checks++;
    if ({len_err, crc_err, crc_ok, frame_len} !== {3'b110, 8'h41}) begin
      failures++;
      $display("[TB] FAIL len_saturate: got %h required %h", {len_err, crc_err, crc_ok, frame_len}, {3'b110, 8'h41});
    end
    idle(1);
  endtask

  task automatic test_reset_mid_frame;
    int w;
    int p0;
    p0 = pulses;
    send_byte(8'h12, 1'b0, w);
    send_byte(8'h34, 1'b0, w);
    send_byte(8'h56, 1'b0, w);
    data_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({result_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL mid_reset_ready: got rv/ready %b required 01", {result_valid, in_ready});
    end
    idle(3);
    checks++;
    if (pulses !== p0) begin
      failures++;
      $display("[TB] FAIL mid_reset_no_result: got %0d pulses required 0", pulses - p0);
    end
    send_byte(8'h01, 1'b0, w);
    send_byte(8'h07, 1'b1, w);
    checks++;
    if (snap() !== {5'b10100, 8'h07, 8'h07, 8'h01}) begin
      failures++;
      $display("[TB] FAIL mid_reset_next: got %h required %h", snap(), {5'b10100, 8'h07, 8'h07, 8'h01});
    end
    idle(1);
  endtask

`ifdef CRC8_CHECKER_ERR_CNT_EN
  task automatic test_err_count;
    int w;
    err_count_clr = 1'b1;
    idle(1);
    err_count_clr = 1'b0;
    checks++;
    if (err_count !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL err_cnt_clear: got %h required 0000", err_count);
    end
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h01, 1'b0, w);
      send_byte(8'h00, 1'b1, w);
      idle(1);
    end
    send_byte(8'h01, 1'b0, w);
    send_byte(8'h07, 1'b1, w);
    idle(1);
    checks++;
    if (err_count !== 16'h0003) begin
      failures++;
      $display("[TB] FAIL err_cnt_three: got %h required 0003", err_count);
    end
    send_byte(8'h01, 1'b0, w);
    send_byte(8'h00, 1'b1, w);
    err_count_clr = 1'b1;
    idle(1);
    err_count_clr = 1'b0;
    checks++;
    if (err_count !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL err_cnt_clr_wins: got %h required 0000", err_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_check_value();
    test_back_to_back();
    test_len_err();
    test_reset_mid_frame();
`ifdef CRC8_CHECKER_ERR_CNT_EN
    test_err_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
